scr1_ahb_sram_slave: RTL and testbench

// AHB-Lite responder (slave) backing a word-addressed SRAM array, answering the core's imem/dmem AHB initiator ports.

---
 rtl/scr1_ahb_sram_slave_if.sv | 21 ++
 rtl/scr1_ahb_sram_slave.sv | 76 +++++++
 tb/tb_scr1_ahb_sram_slave.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/scr1_ahb_sram_slave_if.sv
// scr1_ahb_sram_slave_if: AHB-Lite signals between an initiator and the SRAM responder.
interface scr1_ahb_sram_slave_if;
   logic        hsel;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic [31:0] hrdata;
   logic        hresp;
   modport master (
      output hsel, htrans, haddr, hsize, hwrite, hwdata, hready,
      input  hreadyout, hrdata, hresp
   );
   modport slave (
      input  hsel, htrans, haddr, hsize, hwrite, hwdata, hready,
      output hreadyout, hrdata, hresp
   );
endinterface

// File: rtl/scr1_ahb_sram_slave.sv
// scr1_ahb_sram_slave: AHB-Lite responder over a word-wide SRAM with fixed wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module scr1_ahb_sram_slave #(
   parameter int MEM_POWER_SIZE = 16,
   parameter int WAIT_STATES    = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   scr1_ahb_sram_slave_if.slave ahb
);
   localparam int AW = MEM_POWER_SIZE - 2;
   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] widx_q, widx_d;
   logic [1:0]    boff_q, boff_d;
   logic [1:0]    size_q, size_d;
   logic          write_q, write_d;
   logic          hreadyout_q, hreadyout_d;
   logic          hresp_q, hresp_d;
   logic [31:0]   mem [0:(1<<AW)-1];
   logic          oor, misaligned, legal, done, accept;
   logic [3:0]    be;
   always_comb begin
      oor         = (ahb.haddr >> MEM_POWER_SIZE) != 32'h0;
      misaligned  = (ahb.hsize == 3'd1 && ahb.haddr[0]) || (ahb.hsize == 3'd2 && ahb.haddr[1:0] != 2'b00);
      legal       = !oor && ahb.hsize <= 3'd2 && !misaligned;
      done        = state_q == DATA && cnt_q == 4'd0;
      // a new address phase is only taken when no data phase is stretching or erroring
      accept      = ahb.hsel && ahb.hready && ahb.htrans[1] && (state_q == IDLE || done);
      state_d     = accept ? (legal ? DATA : ERR1) :
                    state_q == DATA ? (done ? IDLE : DATA) :
                    state_q == ERR1 ? ERR2 : IDLE;
      cnt_d       = (accept && legal) ? 4'(WAIT_STATES) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0);
      widx_d      = accept ? ahb.haddr[MEM_POWER_SIZE-1:2] : widx_q;
      boff_d      = accept ? ahb.haddr[1:0] : boff_q;
      size_d      = accept ? ahb.hsize[1:0] : size_q;
      write_d     = accept ? ahb.hwrite : write_q;
      hreadyout_d = state_d == DATA ? cnt_d == 4'd0 : state_d != ERR1;
      hresp_d     = state_d == ERR1 || state_d == ERR2;
      be          = size_q == 2'd0 ? 4'b0001 << boff_q :
                    size_q == 2'd1 ? (boff_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         widx_q      <= '0;
         boff_q      <= 2'd0;
         size_q      <= 2'd0;
         write_q     <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         widx_q      <= widx_d;
         boff_q      <= boff_d;
         size_q      <= size_d;
         write_q     <= write_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   // write commits at the completing edge, so a following read phase sees the new word
   always_ff @(posedge clk)
      if (done && write_q)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[widx_q][8*i +: 8] <= ahb.hwdata[8*i +: 8];
   assign ahb.hreadyout = hreadyout_q;
   assign ahb.hresp     = hresp_q;
   assign ahb.hrdata    = (done && !write_q) ? mem[widx_q] : 32'h0;
   a_err_seq: assert property (@(posedge clk) disable iff (!rst_n) state_q == ERR1 |=> state_q == ERR2);
   a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 4'(WAIT_STATES));
   a_ready:   assert property (@(posedge clk) disable iff (!rst_n)
                 hreadyout_q == (state_q == DATA ? cnt_q == 4'd0 : state_q != ERR1));
endmodule

// File: tb/tb_scr1_ahb_sram_slave.sv
// tb_scr1_ahb_sram_slave: two responders (0 and 2 wait states) on one bus, driven by a
// pipelined master with a scoreboard of expected read data.
module tb_scr1_ahb_sram_slave;
   typedef struct {logic w; logic [31:0] a; logic [2:0] sz; logic [31:0] d;} req_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        hsel = 1'b0;
   logic [1:0]  htrans = 2'b00;
   logic [31:0] haddr = 32'h0;
   logic [2:0]  hsize = 3'd2;
   logic        hwrite = 1'b0;
   logic [31:0] hwdata = 32'h0;
   logic        hreadyout_m, hresp_m;
   logic [31:0] hrdata_m;
   logic [3:0]  cnt_m;
   int          checks = 0;
   int          fails = 0;
   req_t        reqs[$];
   logic [31:0] exp_q[$];
   logic [31:0] model[int];
   scr1_ahb_sram_slave_if if0 ();
   scr1_ahb_sram_slave_if if2 ();
   scr1_ahb_sram_slave #(.MEM_POWER_SIZE(16), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst_n(rst_n), .ahb(if0.slave));
   scr1_ahb_sram_slave #(.MEM_POWER_SIZE(16), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst_n(rst_n), .ahb(if2.slave));
   always #5 clk = ~clk;
   assign hreadyout_m = sel ? if2.hreadyout : if0.hreadyout;
   assign hresp_m     = sel ? if2.hresp : if0.hresp;
   assign hrdata_m    = sel ? if2.hrdata : if0.hrdata;
   assign cnt_m       = sel ? u_ws2.cnt_q : u_ws0.cnt_q;
   assign if0.hsel = hsel & ~sel;
   assign if2.hsel = hsel & sel;
   assign if0.htrans = htrans;
   assign if2.htrans = htrans;
   assign if0.haddr = haddr;
   assign if2.haddr = haddr;
   assign if0.hsize = hsize;
   assign if2.hsize = hsize;
   assign if0.hwrite = hwrite;
   assign if2.hwrite = hwrite;
   assign if0.hwdata = hwdata;
   assign if2.hwdata = hwdata;
   assign if0.hready = hreadyout_m;
   assign if2.hready = hreadyout_m;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s sel=%0d got=%08h exp=%08h t=%0t", tag, sel, got, exp, $time);
      end
   endtask
   function automatic int key(input logic [31:0] a);
      return (int'(sel) << 16) | int'(a >> 2);
   endfunction
   function automatic logic [31:0] mrd(input logic [31:0] a);
      return model.exists(key(a)) ? model[key(a)] : 32'h0;
   endfunction
   task automatic mwr(input req_t r);
      logic [31:0] v = mrd(r.a);
      for (int i = 0; i < 4; i++)
         if (r.sz == 3'd2 || (r.sz == 3'd1 && (i / 2) == int'(r.a[1])) || (r.sz == 3'd0 && i == int'(r.a[1:0])))
            v[8*i +: 8] = r.d[8*i +: 8];
      model[key(r.a)] = v;
   endtask
   task automatic add(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
      req_t r;
      r.w = w; r.a = a; r.sz = sz; r.d = d;
      reqs.push_back(r);
   endtask
   task automatic bus_idle();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0;
   endtask
   // issues every queued request back-to-back; entered and left at #1 after a posedge
   task automatic run_reqs();
      int   idx = 0;
      int   cyc = 0;
      int   budget = 400;
      int   ws = sel ? 2 : 0;
      bit   act = 0;
      bit   rdy;
      req_t dp;
      while ((idx < reqs.size() || act) && budget > 0) begin
         budget--;
         if (idx < reqs.size()) begin
            hsel = 1'b1;
            htrans = (act && reqs[idx].a == dp.a + 32'd4) ? 2'b11 : 2'b10;
            haddr = reqs[idx].a; hsize = reqs[idx].sz; hwrite = reqs[idx].w;
         end else begin
            hsel = 1'b0; htrans = 2'b00;
         end
         hwdata = (act && dp.w) ? dp.d : 32'h0;
         @(negedge clk);
         rdy = hreadyout_m;
         if (act) begin
            chk("cnt", 32'(cnt_m), 32'(ws - cyc));
            if (rdy) begin
               chk("dplen", 32'(cyc + 1), 32'(ws + 1));
               chk("resp", 32'(hresp_m), 32'h0);
               if (!dp.w) begin
                  if (exp_q.size() == 0) chk("sb_underrun", 32'(exp_q.size()), 32'h1);
                  else chk("rdata", hrdata_m, exp_q.pop_front());
               end else chk("wr_rdata", hrdata_m, 32'h0);
            end else chk("wait_rdata", hrdata_m, 32'h0);
            cyc++;
         end
         @(posedge clk); #1;
         if (rdy) begin
            act = idx < reqs.size();
            cyc = 0;
            if (act) begin
               dp = reqs[idx];
               idx++;
               if (dp.w) mwr(dp); else exp_q.push_back(mrd(dp.a));
            end
         end
      end
      bus_idle();
      chk("drained", 32'(idx), 32'(reqs.size()));
      chk("active", 32'(act), 32'h0);
      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      reqs.delete();
   endtask
   // illegal read, then a write attempt during ERR2 that must be ignored
   task automatic err_xfer(input logic [31:0] a, input logic [2:0] sz);
      hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = 1'b0;
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      chk("err1_rdy", 32'(hreadyout_m), 32'h0);
      chk("err1_resp", 32'(hresp_m), 32'h1);
      chk("err1_rdata", hrdata_m, 32'h0);
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h100; hsize = 3'd2; hwrite = 1'b1;
      @(negedge clk);
      chk("err2_rdy", 32'(hreadyout_m), 32'h1);
      chk("err2_resp", 32'(hresp_m), 32'h1);
      @(posedge clk); #1;
      bus_idle();
      hwdata = 32'hBADBAD00;
      @(negedge clk);
      chk("post_err_rdy", 32'(hreadyout_m), 32'h1);
      chk("post_err_resp", 32'(hresp_m), 32'h0);
      @(posedge clk); #1;
      hwdata = 32'h0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, fails);
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("rst_rdy", 32'(hreadyout_m), 32'h1);
         chk("rst_resp", 32'(hresp_m), 32'h0);
         chk("rst_rdata", hrdata_m, 32'h0);
         chk("rst_cnt", 32'(cnt_m), 32'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         add(1'b1, 32'h100, 3'd2, 32'hDEADBEEF);
         add(1'b0, 32'h100, 3'd2, 32'h0);
         run_reqs();
         for (int i = 0; i < 3; i++) add(1'b1, 32'(4 * i), 3'd2, 32'hA0A00000 + 32'(i * 17));
         for (int i = 0; i < 3; i++) add(1'b0, 32'(4 * i), 3'd2, 32'h0);
         run_reqs();
         add(1'b0, 32'h0, 3'd2, 32'h0);
         run_reqs();
         add(1'b1, 32'h200, 3'd2, 32'h11223344);
         add(1'b1, 32'h203, 3'd0, 32'hAA000000);
         add(1'b0, 32'h200, 3'd2, 32'h0);
         add(1'b1, 32'h202, 3'd1, 32'h55660000);
         add(1'b0, 32'h200, 3'd2, 32'h0);
         add(1'b1, 32'h201, 3'd0, 32'h00007700);
         add(1'b1, 32'h200, 3'd1, 32'h0000BEEF);
         add(1'b0, 32'h200, 3'd2, 32'h0);
         run_reqs();
         for (int i = 0; i < 4; i++) add(1'b1, 32'h400 + 32'(4 * i), 3'd2, $urandom);
         for (int i = 3; i >= 0; i--) add(1'b0, 32'h400 + 32'(4 * i), 3'd2, 32'h0);
         run_reqs();
         err_xfer(32'h102, 3'd2);
         err_xfer(32'h00010000, 3'd2);
         err_xfer(32'h101, 3'd1);
         err_xfer(32'h0, 3'd3);
         add(1'b0, 32'h100, 3'd2, 32'h0);
         add(1'b0, 32'h0, 3'd2, 32'h0);
         run_reqs();
      end
      sel = 1'b1;
      add(1'b1, 32'h300, 3'd2, 32'h12345678);
      run_reqs();
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h300; hsize = 3'd2; hwrite = 1'b1;
      @(posedge clk); #1;
      bus_idle();
      hwdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      chk("pre_rst_cnt", 32'(cnt_m), 32'h1);
      chk("pre_rst_rdy", 32'(hreadyout_m), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("arst_rdy", 32'(hreadyout_m), 32'h1);
      chk("arst_resp", 32'(hresp_m), 32'h0);
      chk("arst_rdata", hrdata_m, 32'h0);
      chk("arst_cnt", 32'(cnt_m), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hwdata = 32'h0;
      add(1'b0, 32'h300, 3'd2, 32'h0);
      run_reqs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
